checkpoint_restore_engine: RTL and testbench

CHECKPOINT_RESTORE_ENGINE -- requirements
Module: checkpoint_restore_engine

---
 rtl/checkpoint_restore_engine.sv | 162 ++++++++++++++++
 tb/tb_checkpoint_restore_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_restore_engine.sv
// Dual-bank architectural checkpoint engine: saves x1..xN-1 plus PC,
// and replays the last complete checkpoint into the regfile on recovery.
module checkpoint_restore_engine #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            recover_cpu,
  input  logic            freeze_cpu,
  input  logic            ckpt_req,
  input  logic [XLEN-1:0] cpu_pc,
  output logic [4:0]      rf_rd_addr,
  input  logic [XLEN-1:0] rf_rd_data,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_value,
  output logic            ckpt_busy,
  output logic            ckpt_valid,
  output logic            no_ckpt,
  output logic            recovery_done
);

  localparam logic [4:0] LAST = 5'(NREGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    RESTORE,
    LOADPC,
    DONE,
    HOLD
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       act_q, act_d;
  logic       ckv_q, ckv_d;
  logic       no_ckpt_q, no_ckpt_d;
  logic       rec_q, rec_d;
  logic       rec_edge;
  logic       bank_we;
  logic       spc_we;

  logic [XLEN-1:0] bank_q [2][NREGS];
  logic [XLEN-1:0] spc_q  [2];

  assign rec_edge = recover_cpu & ~rec_q;
  assign rec_d    = recover_cpu;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    act_d     = act_q;
    ckv_d     = ckv_q;
    no_ckpt_d = no_ckpt_q;
    bank_we   = 1'b0;
    spc_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rec_edge) begin
          state_d   = RESTORE;
          idx_d     = 5'd1;
          no_ckpt_d = ~ckv_q;
        end else if (ckpt_req && !freeze_cpu) begin
          spc_we  = 1'b1;
          state_d = SAVE;
          idx_d   = 5'd1;
        end
      end
      SAVE: begin
        // abort leaves the active bank as the last complete checkpoint
        if (rec_edge) begin
          state_d   = RESTORE;
          idx_d     = 5'd1;
          no_ckpt_d = ~ckv_q;
        end else begin
          bank_we = 1'b1;
          if (idx_q == LAST) begin
            act_d   = ~act_q;
            ckv_d   = 1'b1;
            state_d = IDLE;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      RESTORE: begin
        if (idx_q == LAST) begin
          state_d = LOADPC;
          idx_d   = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      LOADPC: state_d = DONE;
      DONE:   state_d = HOLD;
      HOLD: begin
        if (!recover_cpu) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 5'd0;
      act_q     <= 1'b0;
      ckv_q     <= 1'b0;
      no_ckpt_q <= 1'b0;
      rec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      ckv_q     <= ckv_d;
      no_ckpt_q <= no_ckpt_d;
      rec_q     <= rec_d;
    end
  end

  // shadow storage is masked by ckv_q, so it needs no reset
  always_ff @(posedge clk) begin
    if (bank_we) begin
      bank_q[~act_q][idx_q] <= rf_rd_data;
    end
    if (spc_we) begin
      spc_q[~act_q] <= cpu_pc;
    end
  end

  always_comb begin
    rf_rd_addr    = idx_q;
    ckpt_busy     = (state_q == SAVE);
    rf_we         = (state_q == RESTORE);
    pc_load       = (state_q == LOADPC);
    recovery_done = (state_q == DONE);
    rf_wa         = 5'd0;
    rf_wd         = '0;
    pc_value      = '0;
    if (rf_we) begin
      rf_wa = idx_q;
      if (ckv_q) begin
        rf_wd = bank_q[act_q][idx_q];
      end
    end
    if (pc_load) begin
      pc_value = ckv_q ? spc_q[act_q] : PC_RESET;
    end
  end

  assign ckpt_valid = ckv_q;
  assign no_ckpt    = no_ckpt_q;

endmodule

// File: tb/tb_checkpoint_restore_engine.sv
// Scoreboard bench for checkpoint_restore_engine: directed save/restore
// sequences, abort, priority, freeze, hold and async reset cases.
module tb_checkpoint_restore_engine;

  localparam logic [31:0] PCR = 32'h8000_0040;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        recover_cpu = 1'b0;
  logic        freeze_cpu = 1'b0;
  logic        ckpt_req = 1'b0;
  logic [31:0] cpu_pc = '0;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        ckpt_busy;
  logic        ckpt_valid;
  logic        no_ckpt;
  logic        recovery_done;

  logic [31:0] regs     [32];
  logic [31:0] exp_bank [32];

  assign rf_rd_data = regs[rf_rd_addr];

  always #5 clk = ~clk;

  checkpoint_restore_engine #(
    .XLEN     (32),
    .NREGS    (32),
    .PC_RESET (PCR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .recover_cpu   (recover_cpu),
    .freeze_cpu    (freeze_cpu),
    .ckpt_req      (ckpt_req),
    .cpu_pc        (cpu_pc),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rd_data    (rf_rd_data),
    .rf_we         (rf_we),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd),
    .pc_load       (pc_load),
    .pc_value      (pc_value),
    .ckpt_busy     (ckpt_busy),
    .ckpt_valid    (ckpt_valid),
    .no_ckpt       (no_ckpt),
    .recovery_done (recovery_done)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr  [$];
  logic [31:0] exp_pc  [$];
  int          exp_lat [$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rst_start = 0;
  int   done_seen = 0;
  int   busy_seen = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s got %0h want none", name, act);
  endtask

  // monitor: pops the scoreboard whenever the DUT strobes an output
  always @(negedge clk) begin
    wr_t         w;
    logic [31:0] p;
    int          l;
    cyc     <= cyc + 1;
    prev_we <= rf_we;
    if (ckpt_busy === 1'b1) busy_seen++;
    if (rf_we === 1'b1) begin
      if (!prev_we) rst_start <= cyc;
      if (exp_wr.size() == 0) begin
        miss("unexpected_write", {27'd0, rf_wa, rf_wd});
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(rf_wa), 64'(w.a));
        chk("wr_data", 64'(rf_wd), 64'(w.d));
      end
    end
    if (pc_load === 1'b1) begin
      if (exp_pc.size() == 0) begin
        miss("unexpected_pc_load", 64'(pc_value));
      end else begin
        p = exp_pc.pop_front();
        chk("pc_value", 64'(pc_value), 64'(p));
      end
    end
    if (recovery_done === 1'b1) begin
      done_seen++;
      if (exp_lat.size() == 0) begin
        miss("unexpected_done", 64'(done_seen));
      end else begin
        l = exp_lat.pop_front();
        chk("done_latency", 64'(cyc - rst_start + 1), 64'(l));
      end
    end
  end

  task automatic push_writes(input bit zero, input int n);
    wr_t w;
    for (int i = 1; i <= n; i++) begin
      w.a = 5'(i);
      w.d = zero ? 32'd0 : exp_bank[i];
      exp_wr.push_back(w);
    end
  endtask

  task automatic push_full(input bit zero, input logic [31:0] pc);
    push_writes(zero, 31);
    exp_pc.push_back(pc);
    exp_lat.push_back(33);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_seen < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(done_seen), 64'(target));
  endtask

  task automatic settle();
    @(negedge clk);
    recover_cpu = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_ckpt(input logic [31:0] pc);
    int b0;
    int n = 0;
    @(negedge clk);
    ckpt_req = 1'b1;
    cpu_pc   = pc;
    b0       = busy_seen;
    @(negedge clk);
    ckpt_req = 1'b0;
    while (ckpt_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ckpt_valid_latency", 64'(n), 64'd31);
    chk("ckpt_valid_set", 64'(ckpt_valid), 64'd1);
    @(negedge clk);
    chk("ckpt_busy_cycles", 64'(busy_seen - b0), 64'd31);
  endtask

  initial begin
    int b0;
    int d0;
    int n;
    for (int i = 0; i < 32; i++) begin
      regs[i]     = '0;
      exp_bank[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ckpt_valid", 64'(ckpt_valid), 64'd0);
    chk("rst_no_ckpt", 64'(no_ckpt), 64'd0);
    chk("rst_busy", 64'(ckpt_busy), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);

    // full checkpoint then restore
    for (int i = 1; i < 32; i++) begin
      regs[i]     = 32'(i * 16);
      exp_bank[i] = 32'(i * 16);
    end
    do_ckpt(32'h100);
    for (int i = 1; i < 32; i++) regs[i] = 32'hdead_0000 + 32'(i);
    push_full(1'b0, 32'h100);
    @(negedge clk);
    recover_cpu = 1'b1;
    wait_done(1, "restore_a_done");
    chk("restore_a_no_ckpt", 64'(no_ckpt), 64'd0);
    settle();

    // restore without checkpoint after reset
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst2_ckpt_valid", 64'(ckpt_valid), 64'd0);
    push_full(1'b1, PCR);
    @(negedge clk);
    recover_cpu = 1'b1;
    wait_done(2, "nockpt_done");
    chk("nockpt_flag", 64'(no_ckpt), 64'd1);
    settle();

    // abort a second save at SAVE cycle 10
    for (int i = 1; i < 32; i++) begin
      regs[i]     = 32'(i * 16);
      exp_bank[i] = 32'(i * 16);
    end
    do_ckpt(32'h100);
    for (int i = 1; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    push_full(1'b0, 32'h100);
    @(negedge clk);
    ckpt_req = 1'b1;
    cpu_pc   = 32'h200;
    b0       = busy_seen;
    @(negedge clk);
    ckpt_req = 1'b0;
    repeat (9) @(negedge clk);
    recover_cpu = 1'b1;
    wait_done(3, "abort_done");
    chk("abort_busy_cycles", 64'(busy_seen - b0), 64'd10);
    chk("abort_ckpt_valid", 64'(ckpt_valid), 64'd1);
    chk("abort_no_ckpt", 64'(no_ckpt), 64'd0);
    settle();

    // recovery edge wins over ckpt_req in the same cycle
    push_full(1'b0, 32'h100);
    b0 = busy_seen;
    @(negedge clk);
    ckpt_req    = 1'b1;
    cpu_pc      = 32'h300;
    recover_cpu = 1'b1;
    @(negedge clk);
    ckpt_req = 1'b0;
    @(posedge clk);
    #1;
    chk("prio_restore_entered", 64'(rf_we), 64'd1);
    wait_done(4, "prio_done");
    chk("prio_busy_cycles", 64'(busy_seen - b0), 64'd0);

    // recover held high: stays in HOLD, no second done
    d0 = done_seen;
    repeat (40) @(posedge clk);
    chk("hold_no_second_done", 64'(done_seen), 64'(d0));
    settle();

    // ckpt_req while frozen is ignored
    freeze_cpu = 1'b1;
    for (int i = 1; i < 32; i++) regs[i] = 32'h5000 + 32'(i);
    b0 = busy_seen;
    @(negedge clk);
    ckpt_req = 1'b1;
    cpu_pc   = 32'h400;
    @(negedge clk);
    ckpt_req = 1'b0;
    repeat (40) @(negedge clk);
    chk("freeze_busy_cycles", 64'(busy_seen - b0), 64'd0);
    chk("freeze_ckpt_valid", 64'(ckpt_valid), 64'd1);
    freeze_cpu = 1'b0;
    push_full(1'b0, 32'h100);
    @(negedge clk);
    recover_cpu = 1'b1;
    wait_done(5, "freeze_restore_done");
    settle();

    // async reset in the middle of RESTORE
    push_writes(1'b0, 10);
    @(negedge clk);
    recover_cpu = 1'b1;
    n = 0;
    while (exp_wr.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("midrst_writes_seen", 64'(exp_wr.size()), 64'd0);
    #2;
    reset       = 1'b0;
    recover_cpu = 1'b0;
    #1;
    chk("midrst_strobes",
        64'({rf_we, pc_load, recovery_done, ckpt_busy}), 64'd0);
    chk("midrst_status", 64'({ckpt_valid, no_ckpt}), 64'd0);
    chk("midrst_rf_wa", 64'(rf_wa), 64'd0);
    chk("midrst_rf_wd", 64'(rf_wd), 64'd0);
    chk("midrst_pc_value", 64'(pc_value), 64'd0);
    chk("midrst_rd_addr", 64'(rf_rd_addr), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_full(1'b1, PCR);
    @(negedge clk);
    recover_cpu = 1'b1;
    wait_done(6, "postrst_done");
    chk("postrst_no_ckpt", 64'(no_ckpt), 64'd1);
    settle();

    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("pc_queue_empty", 64'(exp_pc.size()), 64'd0);
    chk("lat_queue_empty", 64'(exp_lat.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
